mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: word-address bits, giving 2^14 x 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..4: cycles from request accept to response valid.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_flush, input, 1 bit: pipeline flush from writeback.
REQ-006 SHALL have port i_if_req_valid, input, 1 bit: fetch read request.
REQ-007 SHALL have port i_if_req_addr, input, 32 bits: fetch byte address.
REQ-008 SHALL have port o_if_req_ready, output, 1 bit: fetch request accepted this cycle.
REQ-009 SHALL have port o_if_resp_valid, output, 1 bit: fetch response.
REQ-010 SHALL have port o_if_resp_data, output, 32 bits: fetch read data.
REQ-011 SHALL have port i_ls_req_valid, input, 1 bit: load/store request.
REQ-012 SHALL have port i_ls_req_addr, input, 32 bits: load/store byte address.
REQ-013 SHALL have port i_ls_req_write, input, 1 bit: 1 means store, 0 means load.
REQ-014 SHALL have port i_ls_req_mask, input, 4 bits: store byte enables; bit n enables byte n.
REQ-015 SHALL have port i_ls_req_wdata, input, 32 bits: store data.
REQ-016 SHALL have port o_ls_req_ready, output, 1 bit: load/store request accepted this cycle.
REQ-017 SHALL have port o_ls_resp_valid, output, 1 bit: load/store response.
REQ-018 SHALL have port o_ls_resp_data, output, 32 bits: load data; 0 for stores.

Function
REQ-019 SHALL hold one memory array of 2^ADDR_WIDTH 32-bit words, with at most one access accepted per cycle.
REQ-020 SHALL form the word index as addr[ADDR_WIDTH+1:2]; addr[1:0] and the upper bits are ignored, so addresses wrap modulo the array size.
REQ-021 SHALL accept a request when its valid is high and it holds the grant. The ready output is combinational, and at most one ready is high per cycle.
REQ-022 SHALL arbitrate round-robin when both ports are valid: the grant goes to the port not granted most recently. When only one port is valid, that port is granted.
REQ-023 SHALL initialise the round-robin pointer at reset so that the load/store port wins the first contention.
REQ-024 SHALL update the round-robin pointer only on an accept.
REQ-025 SHALL NOT accept a fetch request in any cycle where i_flush is high. Load/store requests are unaffected by i_flush.
REQ-026 SHALL perform the masked store write in the accept cycle; bytes with mask bit 0 remain unchanged.
REQ-027 SHALL issue the response for each accepted request exactly LATENCY cycles after accept, as a single-cycle valid pulse on the originating port.
REQ-028 SHALL return responses in accept order, with no response back-pressure.
REQ-029 SHALL return, for a load or fetch accepted in cycle N, the memory contents including every store accepted in cycles before N.
REQ-030 SHALL drive o_ls_resp_data to 0 for a store response; the store response is an acknowledgement only.
REQ-031 SHALL hold each response data output at 0 in any cycle where its valid is low.
REQ-032 SHALL track in-flight requests in a LATENCY-deep shift pipeline; each entry holds valid, port id, is-store flag and data.
REQ-033 SHALL, when i_flush is high, squash every in-flight fetch entry so that its o_if_resp_valid never asserts. In-flight load/store entries SHALL still complete.
REQ-034 SHALL, when i_flush is high in the same cycle that a fetch response would be presented, suppress that response.

Reset
REQ-035 SHALL, while i_rst is high, drive every output to 0: ready, valid and data outputs alike.
REQ-036 SHALL, while i_rst is high, clear all pipeline valid bits and reset the round-robin pointer.
REQ-037 SHALL leave memory contents unaffected by reset.
REQ-038 SHALL, when reset is asserted mid-operation, discard every in-flight request; no response is produced for it after reset deasserts.
REQ-039 SHALL be able to accept a new request in the first cycle after i_rst deasserts.

Verification
REQ-040 SHALL verify store then load: LS store addr 0x10, mask 0xF, data 0xDEADBEEF; LS load 0x10 the next cycle -> load response 0xDEADBEEF exactly 2 cycles after its accept.
REQ-041 SHALL verify byte masking: word 0x20 = 0x11223344; store mask 0x2, data 0x0000AA00; load 0x20 -> 0x1122AA44.
REQ-042 SHALL verify arbitration: both ports valid every cycle for 6 cycles -> grants alternate LS, IF, LS, IF, LS, IF, and exactly one ready is high per cycle.
REQ-043 SHALL verify flush: IF accepted in cycle N, i_flush high in cycle N+1 -> no o_if_resp_valid. An LS load accepted in cycle N+1 with i_flush high still responds in cycle N+3.
REQ-044 SHALL verify address wrap: with ADDR_WIDTH=14, store to 0x10000, then load 0x00000 -> returns the stored data. Load of 0x10003 -> returns the same word.
REQ-045 SHALL verify reset mid-flight: i_rst pulsed one cycle after an accept -> no response appears, all outputs are 0 during reset, and a load accepted after reset returns the pre-reset stored data.

Source files
------------

// File: rtl/mem_responder.sv
// Single-ported word memory serving a fetch port and a load/store port with
// round-robin arbitration, fixed response latency and fetch-flush squashing.
module mem_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_if_req_valid,
  input  logic [31:0] i_if_req_addr,
  output logic        o_if_req_ready,
  output logic        o_if_resp_valid,
  output logic [31:0] o_if_resp_data,
  input  logic        i_ls_req_valid,
  input  logic [31:0] i_ls_req_addr,
  input  logic        i_ls_req_write,
  input  logic [3:0]  i_ls_req_mask,
  input  logic [31:0] i_ls_req_wdata,
  output logic        o_ls_req_ready,
  output logic        o_ls_resp_valid,
  output logic [31:0] o_ls_resp_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic        valid;
    logic        is_ls;
    logic        is_store;
    logic [31:0] data;
  } entry_t;

  logic [31:0]           mem [DEPTH];
  entry_t                pipe [LATENCY];
  entry_t                tail;
  logic                  last_if;
  logic                  if_ok;
  logic                  ls_ok;
  logic                  grant_if;
  logic                  grant_ls;
  logic [ADDR_WIDTH-1:0] if_idx;
  logic [ADDR_WIDTH-1:0] ls_idx;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           rd_word;
  logic                  unused_addr;

  assign if_idx  = i_if_req_addr[ADDR_WIDTH+1:2];
  assign ls_idx  = i_ls_req_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{i_if_req_addr[31:ADDR_WIDTH+2], i_if_req_addr[1:0],
                         i_ls_req_addr[31:ADDR_WIDTH+2], i_ls_req_addr[1:0]};

  // A flushed fetch does not count as contending, so it cannot steal the grant.
  always_comb begin
    if_ok    = i_if_req_valid & ~i_flush & ~i_rst;
    ls_ok    = i_ls_req_valid & ~i_rst;
    grant_ls = ls_ok & (~if_ok | last_if);
    grant_if = if_ok & ~grant_ls;
    acc_idx  = grant_ls ? ls_idx : if_idx;
    rd_word  = mem[acc_idx];
  end

  assign o_if_req_ready = grant_if;
  assign o_ls_req_ready = grant_ls;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_if <= 1'b1;
    end else if (grant_if) begin
      last_if <= 1'b1;
    end else if (grant_ls) begin
      last_if <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (grant_ls && i_ls_req_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_ls_req_mask[b]) begin
          mem[ls_idx][8*b +: 8] <= i_ls_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Fetch entries lose their valid bit as they shift past any flush cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid:    grant_if | grant_ls,
                   is_ls:    grant_ls,
                   is_store: grant_ls & i_ls_req_write,
                   data:     rd_word};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe[i] <= '{valid:    pipe[i-1].valid & ~(i_flush & ~pipe[i-1].is_ls),
                     is_ls:    pipe[i-1].is_ls,
                     is_store: pipe[i-1].is_store,
                     data:     pipe[i-1].data};
      end
    end
  end

  assign tail = pipe[LATENCY-1];

  always_comb begin
    o_if_resp_valid = tail.valid & ~tail.is_ls & ~i_flush & ~i_rst;
    o_ls_resp_valid = tail.valid & tail.is_ls & ~i_rst;
    o_if_resp_data  = o_if_resp_valid ? tail.data : '0;
    o_ls_resp_data  = (o_ls_resp_valid && !tail.is_store) ? tail.data : '0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_responder;

  localparam int AW  = 14;
  localparam int LAT = 2;
  localparam int unsigned DEPTH = 2 ** AW;

  logic        i_clk;
  logic        i_rst;
  logic        i_flush;
  logic        i_if_req_valid;
  logic [31:0] i_if_req_addr;
  logic        o_if_req_ready;
  logic        o_if_resp_valid;
  logic [31:0] o_if_resp_data;
  logic        i_ls_req_valid;
  logic [31:0] i_ls_req_addr;
  logic        i_ls_req_write;
  logic [3:0]  i_ls_req_mask;
  logic [31:0] i_ls_req_wdata;
  logic        o_ls_req_ready;
  logic        o_ls_resp_valid;
  logic [31:0] o_ls_resp_data;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_flush         (i_flush),
    .i_if_req_valid  (i_if_req_valid),
    .i_if_req_addr   (i_if_req_addr),
    .o_if_req_ready  (o_if_req_ready),
    .o_if_resp_valid (o_if_resp_valid),
    .o_if_resp_data  (o_if_resp_data),
    .i_ls_req_valid  (i_ls_req_valid),
    .i_ls_req_addr   (i_ls_req_addr),
    .i_ls_req_write  (i_ls_req_write),
    .i_ls_req_mask   (i_ls_req_mask),
    .i_ls_req_wdata  (i_ls_req_wdata),
    .o_ls_req_ready  (o_ls_req_ready),
    .o_ls_resp_valid (o_ls_resp_valid),
    .o_ls_resp_data  (o_ls_resp_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          due;
    bit          is_ls;
    bit          known;
    logic [31:0] data;
  } resp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] model_mem [int unsigned];
  resp_t       pend [$];
  bit          last_was_ls;     // port granted most recently
  logic        got_if_rdy, got_ls_rdy;
  logic [31:0] last_ls_data;
  int          last_ls_cyc;
  int          n_if_resp = 0;
  int          n_ls_resp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  // One clock cycle: inputs were set at posedge+1, outputs sampled at negedge.
  task automatic tick();
    bit          exp_ifv, exp_lsv, chk_ifd, chk_lsd, if_ok, ls_ok, g_if, g_ls;
    logic [31:0] exp_ifd, exp_lsd;
    int unsigned idx;
    resp_t       e, keep[$];
    @(negedge i_clk);
    got_if_rdy = o_if_req_ready;
    got_ls_rdy = o_ls_req_ready;
    if (o_if_resp_valid) n_if_resp++;
    if (o_ls_resp_valid) begin
      n_ls_resp++;
      last_ls_data = o_ls_resp_data;
      last_ls_cyc  = cyc;
    end
    exp_ifv = 0; exp_lsv = 0; exp_ifd = '0; exp_lsd = '0; chk_ifd = 1; chk_lsd = 1;
    g_if = 0; g_ls = 0;
    if (i_rst) begin
      pend.delete();
      last_was_ls = 0;
    end else begin
      if (i_flush) begin
        foreach (pend[j]) if (pend[j].is_ls) keep.push_back(pend[j]);
        pend = keep;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        if (e.is_ls) begin exp_lsv = 1; exp_lsd = e.data; chk_lsd = e.known; end
        else         begin exp_ifv = 1; exp_ifd = e.data; chk_ifd = e.known; end
      end
      if_ok = i_if_req_valid && !i_flush;
      ls_ok = i_ls_req_valid;
      if (if_ok && ls_ok) begin g_ls = !last_was_ls; g_if = last_was_ls; end
      else begin g_ls = ls_ok; g_if = if_ok; end
    end
    check("if_req_ready", 32'(o_if_req_ready), 32'(g_if));
    check("ls_req_ready", 32'(o_ls_req_ready), 32'(g_ls));
    check("if_resp_valid", 32'(o_if_resp_valid), 32'(exp_ifv));
    check("ls_resp_valid", 32'(o_ls_resp_valid), 32'(exp_lsv));
    if (chk_ifd) check("if_resp_data", o_if_resp_data, exp_ifd);
    if (chk_lsd) check("ls_resp_data", o_ls_resp_data, exp_lsd);
    if (g_ls) begin
      last_was_ls = 1;
      idx = (i_ls_req_addr / 4) % DEPTH;
      if (i_ls_req_write) begin
        if (model_mem.exists(idx))
          model_mem[idx] = (model_mem[idx] & ~byte_mask(i_ls_req_mask)) |
                           (i_ls_req_wdata & byte_mask(i_ls_req_mask));
        else if (i_ls_req_mask == 4'hF)
          model_mem[idx] = i_ls_req_wdata;
        pend.push_back('{due: cyc + LAT, is_ls: 1, known: 1, data: '0});
      end else begin
        pend.push_back('{due: cyc + LAT, is_ls: 1, known: model_mem.exists(idx),
                         data: model_mem.exists(idx) ? model_mem[idx] : '0});
      end
    end
    if (g_if) begin
      last_was_ls = 0;
      idx = (i_if_req_addr / 4) % DEPTH;
      pend.push_back('{due: cyc + LAT, is_ls: 0, known: model_mem.exists(idx),
                       data: model_mem.exists(idx) ? model_mem[idx] : '0});
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    i_if_req_valid = 0; i_ls_req_valid = 0; i_ls_req_write = 0; i_flush = 0;
  endtask

  task automatic ls(input bit wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    i_ls_req_valid = 1; i_ls_req_write = wr; i_ls_req_addr = a;
    i_ls_req_mask = m; i_ls_req_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w = 32'(64 + $urandom_range(0, 7));
    return ($urandom << 16) | (w << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int mark;
    int cnt;
    i_rst = 1; i_flush = 0;
    i_if_req_valid = 0; i_if_req_addr = '0;
    i_ls_req_valid = 0; i_ls_req_addr = '0; i_ls_req_write = 0;
    i_ls_req_mask = '0; i_ls_req_wdata = '0;
    repeat (3) tick();
    i_rst = 0;

    // Contention from reset: LS first, then alternate; stores and fetches share a word.
    i_if_req_valid = 1; i_if_req_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      ls(1, 32'h300, 4'hF, $urandom);
      tick();
      check("arb_ls_grant", 32'(got_ls_rdy), 32'(k % 2 == 0));
      check("arb_one_ready", 32'(got_if_rdy) + 32'(got_ls_rdy), 32'd1);
    end
    idle(); repeat (3) tick();

    // Store then load back-to-back.
    ls(1, 32'h10, 4'hF, 32'hDEADBEEF); tick();
    ls(0, 32'h10, 4'h0, '0); mark = cyc; tick();
    idle(); repeat (3) tick();
    check("st_ld_data", last_ls_data, 32'hDEADBEEF);
    check("st_ld_latency", 32'(last_ls_cyc), 32'(mark + 2));

    // Byte-masked store.
    ls(1, 32'h20, 4'hF, 32'h11223344); tick();
    ls(1, 32'h20, 4'h2, 32'h0000AA00); tick();
    ls(0, 32'h20, 4'h0, '0); tick();
    idle(); repeat (3) tick();
    check("mask_data", last_ls_data, 32'h1122AA44);

    // Flush one cycle after a fetch accept; a load during the flush still completes.
    cnt = n_if_resp;
    i_if_req_valid = 1; i_if_req_addr = 32'h300; mark = cyc; tick();
    check("flush_if_acc", 32'(got_if_rdy), 32'd1);
    i_if_req_valid = 0; i_flush = 1; ls(0, 32'h10, 4'h0, '0); tick();
    check("flush_ls_acc", 32'(got_ls_rdy), 32'd1);
    idle(); repeat (3) tick();
    check("flush_if_none", 32'(n_if_resp - cnt), 32'd0);
    check("flush_ls_cycle", 32'(last_ls_cyc), 32'(mark + 3));
    check("flush_ls_data", last_ls_data, 32'hDEADBEEF);

    // Flush coinciding with the fetch response cycle.
    cnt = n_if_resp;
    i_if_req_valid = 1; i_if_req_addr = 32'h300; tick();
    idle(); tick();
    i_flush = 1; tick();
    idle(); repeat (2) tick();
    check("flush_late_none", 32'(n_if_resp - cnt), 32'd0);

    // Address wrap modulo array size.
    ls(1, 32'h10000, 4'hF, 32'h5A5A1234); tick();
    ls(0, 32'h00000, 4'h0, '0); tick();
    idle(); tick(); tick();
    check("wrap_low", last_ls_data, 32'h5A5A1234);
    ls(0, 32'h10003, 4'h0, '0); tick();
    idle(); tick(); tick();
    check("wrap_offset", last_ls_data, 32'h5A5A1234);

    // Reset pulse one cycle after a load accept.
    ls(1, 32'h40, 4'hF, 32'hCAFEF00D); tick();
    ls(0, 32'h40, 4'h0, '0); tick();
    cnt = n_ls_resp;
    i_rst = 1; i_if_req_valid = 1; tick();
    check("rst_no_ready", 32'(got_if_rdy) + 32'(got_ls_rdy), 32'd0);
    i_rst = 0; i_if_req_valid = 0; tick();
    check("rst_first_acc", 32'(got_ls_rdy), 32'd1);
    idle(); repeat (3) tick();
    check("rst_resp_count", 32'(n_ls_resp - cnt), 32'd1);
    check("rst_mem_kept", last_ls_data, 32'hCAFEF00D);

    // Random traffic over a small initialised window.
    for (int w = 64; w < 72; w++) begin
      ls(1, 32'(w) << 2, 4'hF, $urandom); tick();
    end
    idle(); repeat (3) tick();
    for (int k = 0; k < 400; k++) begin
      i_rst          = ($urandom_range(0, 99) < 2);
      i_flush        = ($urandom_range(0, 99) < 15);
      i_if_req_valid = ($urandom_range(0, 9) < 6);
      i_if_req_addr  = rand_addr();
      i_ls_req_valid = ($urandom_range(0, 9) < 6);
      i_ls_req_addr  = rand_addr();
      i_ls_req_write = $urandom_range(0, 1);
      i_ls_req_mask  = 4'($urandom);
      i_ls_req_wdata = $urandom;
      tick();
    end
    i_rst = 0; idle(); repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
